regfile_wb_unit: RTL and testbench

- Write-side front end of the register file: accepts writeback results from the ALU and from memory loads, and drives the register file's single write port (WE/RW/DIN).
- Buffers load results in a small FIFO and arbitrates them against ALU results.
- Keeps a per-register pending-load scoreboard (BUSY) for the issue stage to stall on.
- Optionally forwards the in-flight write to the two register-file read ports.

---
 rtl/regfile_wb_unit_pkg.sv | 11 +
 rtl/regfile_wb_unit_if.sv | 36 +++
 rtl/regfile_wb_unit_wb_fifo.sv | 39 +++
 rtl/regfile_wb_unit.sv | 74 +++++++
 tb/tb_regfile_wb_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_unit_pkg.sv
// regfile_wb_unit_pkg: shared constants and types for the register-file writeback front end.
package regfile_wb_unit_pkg;
    localparam int N_REGS = 32;
    localparam int DATA_W = 64;
    localparam int REG_AW = $clog2(N_REGS);
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry;
    typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM} wb_src;
endpackage

// File: rtl/regfile_wb_unit_if.sv
// regfile_wb_unit_if: ALU/issue/load inputs, register-file write port, scoreboard and read ports.
interface regfile_wb_unit_if #(
    parameter int N = regfile_wb_unit_pkg::N_REGS,
    parameter int SIZE = regfile_wb_unit_pkg::DATA_W
);
    import regfile_wb_unit_pkg::*;
    localparam int AW = $clog2(N);
    logic alu_valid;
    logic [AW-1:0] alu_rd;
    logic [SIZE-1:0] alu_data;
    logic issue_valid;
    logic [AW-1:0] issue_rd;
    logic mem_valid;
    logic mem_ready;
    logic [AW-1:0] mem_rd;
    logic [SIZE-1:0] mem_data;
    logic flush;
    logic we;
    logic [AW-1:0] rw;
    logic [SIZE-1:0] din;
    logic [N-1:0] busy;
    logic [AW-1:0] ra, rb;
    logic [SIZE-1:0] da_rf, db_rf;
    logic [SIZE-1:0] da, db;
    wb_src src;
    modport master (
        output alu_valid, alu_rd, alu_data, issue_valid, issue_rd, mem_valid, mem_rd, mem_data,
               flush, ra, rb, da_rf, db_rf,
        input  mem_ready, we, rw, din, busy, da, db, src
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, issue_valid, issue_rd, mem_valid, mem_rd, mem_data,
               flush, ra, rb, da_rf, db_rf,
        output mem_ready, we, rw, din, busy, da, db, src
    );
endinterface

// File: rtl/regfile_wb_unit_wb_fifo.sv
// wb_fifo: synchronous FIFO of writeback entries; wrap-bit pointers, push allowed when full if popping.
module wb_fifo
    import regfile_wb_unit_pkg::*;
#(
    parameter type T = wb_entry,
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  T     din,
    output T     head,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    T mem [DEPTH];
    assign empty = wp == rp;
    assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head = mem[rp[AW-1:0]];
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
endmodule

// File: rtl/regfile_wb_unit.sv
// regfile_wb_unit: drives the register-file write port from ALU results and buffered loads, tracks pending loads.
// Define WB_FORWARD_EN to forward the in-flight write onto the DA/DB read ports.
module regfile_wb_unit
    import regfile_wb_unit_pkg::*;
#(
    parameter int N = N_REGS,
    parameter int SIZE = DATA_W,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    regfile_wb_unit_if.slave bus
);
    localparam int AW = $clog2(N);
    typedef struct packed {
        logic [AW-1:0] rd;
        logic [SIZE-1:0] data;
    } entry_t;
    entry_t head, mem_in;
    logic full, empty, push, pop;
    logic [N-1:0] set_m, clr_m, busy_nxt;
    assign bus.mem_ready = !full;
    assign mem_in = {bus.mem_rd, bus.mem_data};
    assign push = bus.mem_valid && !full && !bus.flush;
    assign pop = !bus.flush && !bus.alu_valid && !empty;
    wb_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(bus.flush),
        .din(mem_in), .head(head), .full(full), .empty(empty)
    );
    // An issue to the same register as the popping load wins; x0 is never pending.
    always_comb begin
        set_m = bus.issue_valid ? N'(1) << bus.issue_rd : '0;
        clr_m = pop ? N'(1) << head.rd : '0;
        busy_nxt = ((bus.busy & ~clr_m) | set_m) & ~N'(1);
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.we <= 1'b0;
            bus.rw <= '0;
            bus.din <= '0;
            bus.busy <= '0;
            bus.src <= WB_NONE;
        end else if (bus.flush) begin
            bus.we <= 1'b0;
            bus.busy <= '0;
            bus.src <= WB_NONE;
        end else begin
            bus.busy <= busy_nxt;
            if (bus.alu_valid) begin
                bus.we <= bus.alu_rd != '0;
                bus.rw <= bus.alu_rd;
                bus.din <= bus.alu_data;
                bus.src <= WB_ALU;
            end else if (!empty) begin
                bus.we <= head.rd != '0;
                bus.rw <= head.rd;
                bus.din <= head.data;
                bus.src <= WB_MEM;
            end else begin
                bus.we <= 1'b0;
                bus.src <= WB_NONE;
            end
        end
    end
`ifdef WB_FORWARD_EN
    assign bus.da = (bus.we && bus.rw == bus.ra && bus.ra != '0) ? bus.din : bus.da_rf;
    assign bus.db = (bus.we && bus.rw == bus.rb && bus.rb != '0) ? bus.din : bus.db_rf;
`else
    logic unused_sel;
    assign unused_sel = ^{bus.ra, bus.rb};
    assign bus.da = bus.da_rf;
    assign bus.db = bus.db_rf;
`endif
endmodule

// File: tb/tb_regfile_wb_unit.sv
// tb_regfile_wb_unit: directed vector table, hand sequences and randomized run against a queue-based model.
module tb_regfile_wb_unit;
    localparam int DEPTH = 4;
`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    typedef struct {
        logic av; logic [4:0] ard; logic [63:0] ad;
        logic iv; logic [4:0] ird;
        logic mv; logic [4:0] mrd; logic [63:0] md;
        logic fl;
        logic e_we; logic [4:0] e_rw; logic [63:0] e_din; logic [31:0] e_busy; logic e_rdy;
    } vec_t;
    typedef struct {logic [4:0] rd; logic [63:0] data;} ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    vec_t tv[$];
    ent_t q[$];
    logic m_we;
    logic [4:0] m_rw;
    logic [63:0] m_din;
    logic [31:0] m_busy;

    regfile_wb_unit_if bus ();
    regfile_wb_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                         input logic iv, input logic [4:0] ird,
                         input logic mv, input logic [4:0] mrd, input logic [63:0] md, input logic fl);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_data = ad;
        bus.issue_valid = iv; bus.issue_rd = ird;
        bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_data = md;
        bus.flush = fl;
    endtask

    function automatic vec_t v(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                               input logic iv, input logic [4:0] ird,
                               input logic mv, input logic [4:0] mrd, input logic [63:0] md, input logic fl,
                               input logic we, input logic [4:0] rw, input logic [63:0] din,
                               input logic [31:0] busy, input logic rdy);
        vec_t r;
        r.av = av; r.ard = ard; r.ad = ad; r.iv = iv; r.ird = ird;
        r.mv = mv; r.mrd = mrd; r.md = md; r.fl = fl;
        r.e_we = we; r.e_rw = rw; r.e_din = din; r.e_busy = busy; r.e_rdy = rdy;
        return r;
    endfunction

    // Reference: load buffer as a queue, pending loads as a bit set, applied once per clock edge.
    task automatic model_edge();
        ent_t e;
        bit acc;
        if (!rst_n) begin
            q.delete(); m_we = 0; m_rw = 0; m_din = 0; m_busy = 0;
        end else if (bus.flush) begin
            q.delete(); m_we = 0; m_busy = 0;
        end else begin
            acc = bus.mem_valid && q.size() < DEPTH;
            if (bus.alu_valid) begin
                m_we = bus.alu_rd != 0; m_rw = bus.alu_rd; m_din = bus.alu_data;
            end else if (q.size() > 0) begin
                e = q.pop_front();
                m_we = e.rd != 0; m_rw = e.rd; m_din = e.data; m_busy[e.rd] = 1'b0;
            end else m_we = 0;
            if (acc) q.push_back('{rd: bus.mem_rd, data: bus.mem_data});
            if (bus.issue_valid && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
        end
    endtask

    initial begin
        bus.ra = 0; bus.rb = 0; bus.da_rf = 0; bus.db_rf = 0;
        drive(0, 0, 0, 0, 0, 1, 3, 64'h33, 0);
        tick();
        tick();
        chk("reset_we", bus.we, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_ready", bus.mem_ready, 1);
        chk("reset_rw", bus.rw, 0);
        chk("reset_din", bus.din, 0);
        rst_n = 1;

        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 0,0,64'h0,0,1));
        tv.push_back(v(1,5,'hDEAD,0,0,  0,0,0,       0, 1,5,'hDEAD,0,1));
        tv.push_back(v(1,0,'h1234,0,0,  0,0,0,       0, 0,0,'h1234,0,1));
        tv.push_back(v(1,1,'hA1,  0,0,  1,7,'h77,    0, 1,1,'hA1,0,1));
        tv.push_back(v(1,2,'hA2,  0,0,  1,8,'h88,    0, 1,2,'hA2,0,1));
        tv.push_back(v(1,3,'hA3,  0,0,  0,0,0,       0, 1,3,'hA3,0,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 1,7,'h77,0,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 1,8,'h88,0,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 0,8,'h88,0,1));
        tv.push_back(v(1,4,'hB4,  0,0,  1,10,'h100,  0, 1,4,'hB4,0,1));
        tv.push_back(v(1,4,'hB5,  0,0,  1,11,'h101,  0, 1,4,'hB5,0,1));
        tv.push_back(v(1,4,'hB6,  0,0,  1,12,'h102,  0, 1,4,'hB6,0,1));
        tv.push_back(v(1,4,'hB7,  0,0,  1,13,'h103,  0, 1,4,'hB7,0,0));
        tv.push_back(v(0,0,0,     0,0,  1,14,'h104,  0, 1,10,'h100,0,1));
        tv.push_back(v(0,0,0,     0,0,  1,14,'h104,  0, 1,11,'h101,0,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 1,12,'h102,0,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 1,13,'h103,0,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 1,14,'h104,0,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 0,14,'h104,0,1));
        tv.push_back(v(0,0,0,     1,9,  0,0,0,       0, 0,14,'h104,'h200,1));
        tv.push_back(v(0,0,0,     0,0,  1,9,'h99,    0, 0,14,'h104,'h200,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 1,9,'h99,0,1));
        tv.push_back(v(0,0,0,     1,9,  1,9,'h98,    0, 0,9,'h99,'h200,1));
        tv.push_back(v(0,0,0,     1,9,  0,0,0,       0, 1,9,'h98,'h200,1));
        tv.push_back(v(0,0,0,     0,0,  1,9,'h97,    0, 0,9,'h98,'h200,1));
        tv.push_back(v(1,9,'hC9,  0,0,  0,0,0,       0, 1,9,'hC9,'h200,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 1,9,'h97,0,1));
        tv.push_back(v(0,0,0,     1,0,  0,0,0,       0, 0,9,'h97,0,1));
        tv.push_back(v(0,0,0,     0,0,  1,0,'h55,    0, 0,9,'h97,0,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 0,0,'h55,0,1));
        tv.push_back(v(1,1,'hE1,  1,20, 1,20,'h200,  0, 1,1,'hE1,'h100000,1));
        tv.push_back(v(1,1,'hE2,  1,21, 1,21,'h201,  0, 1,1,'hE2,'h300000,1));
        tv.push_back(v(1,1,'hE3,  1,22, 1,22,'h202,  0, 1,1,'hE3,'h700000,1));
        tv.push_back(v(1,2,'hF0,  1,23, 1,24,'h203,  1, 0,1,'hE3,0,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 0,1,'hE3,0,1));
        tv.push_back(v(0,0,0,     0,0,  0,0,0,       0, 0,1,'hE3,0,1));

        foreach (tv[i]) begin
            drive(tv[i].av, tv[i].ard, tv[i].ad, tv[i].iv, tv[i].ird, tv[i].mv, tv[i].mrd, tv[i].md, tv[i].fl);
            tick();
            chk($sformatf("vec%0d_we", i), bus.we, tv[i].e_we);
            chk($sformatf("vec%0d_rw", i), bus.rw, tv[i].e_rw);
            chk($sformatf("vec%0d_din", i), bus.din, tv[i].e_din);
            chk($sformatf("vec%0d_busy", i), bus.busy, tv[i].e_busy);
            chk($sformatf("vec%0d_ready", i), bus.mem_ready, tv[i].e_rdy);
        end

        drive(1, 3, 64'h42, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.ra = 3; bus.da_rf = 64'h11; bus.rb = 4; bus.db_rf = 64'h22;
        #1;
        chk("fwd_da_hit", bus.da, FWD ? 64'h42 : 64'h11);
        chk("fwd_db_miss", bus.db, 64'h22);
        bus.rb = 3;
        #1;
        chk("fwd_db_hit", bus.db, FWD ? 64'h42 : 64'h22);
        drive(1, 0, 64'h42, 0, 0, 0, 0, 0, 0);
        tick();
        bus.ra = 0;
        #1;
        chk("fwd_x0", bus.da, 64'h11);
        bus.ra = 0; bus.rb = 0;

        drive(1, 1, 64'h1, 1, 5, 1, 5, 64'h5, 0);
        tick();
        drive(1, 1, 64'h2, 0, 0, 1, 6, 64'h6, 0);
        tick();
        chk("pre_rst_busy", bus.busy, 32'h20);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 0;
        tick();
        chk("mid_rst_we", bus.we, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ready", bus.mem_ready, 1);
        rst_n = 1;
        tick();
        chk("post_rst_we", bus.we, 0);

        rst_n = 0;
        model_edge();
        tick();
        rst_n = 1;
        for (int c = 0; c < 600; c++) begin
            rst_n = $urandom_range(0, 99) != 0;
            bus.flush = $urandom_range(0, 39) == 0;
            bus.alu_valid = $urandom_range(0, 2) == 0;
            bus.alu_rd = 5'($urandom);
            bus.alu_data = {$urandom, $urandom};
            bus.issue_valid = $urandom_range(0, 3) == 0;
            bus.issue_rd = 5'($urandom);
            if (!(bus.mem_valid && !bus.mem_ready)) begin
                bus.mem_valid = 1'($urandom_range(0, 1));
                bus.mem_rd = 5'($urandom);
                bus.mem_data = {$urandom, $urandom};
            end
            bus.ra = $urandom_range(0, 1) ? m_rw : 5'($urandom);
            bus.rb = $urandom_range(0, 1) ? m_rw : 5'($urandom);
            bus.da_rf = {$urandom, $urandom};
            bus.db_rf = {$urandom, $urandom};
            #1;
            chk("rnd_da", bus.da, (FWD && m_we && m_rw == bus.ra && bus.ra != 0) ? m_din : bus.da_rf);
            chk("rnd_db", bus.db, (FWD && m_we && m_rw == bus.rb && bus.rb != 0) ? m_din : bus.db_rf);
            model_edge();
            tick();
            chk("rnd_we", bus.we, m_we);
            chk("rnd_rw", bus.rw, m_rw);
            chk("rnd_din", bus.din, m_din);
            chk("rnd_busy", bus.busy, m_busy);
            chk("rnd_ready", bus.mem_ready, q.size() < DEPTH);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
